// File: rtl/fir_coeff_loader_if.sv
// Coefficient-load bus between a serial host (master) and the FIR coefficient loader (slave).
// Carries the per-tap handshake plus the committed packed coefficient set and status.
interface fir_coeff_loader_if #(
    parameter int NB_COEFFS = 8,
    parameter int N_COEFFS  = 8,
    parameter int NB_IDX    = $clog2(N_COEFFS)
);
    logic                              i_start;
    logic                              i_abort;
    logic                              i_valid;
    logic signed [NB_COEFFS-1:0]       i_coeff;
    logic                              o_ready;
    logic [NB_COEFFS*N_COEFFS-1:0]     o_coeffs;
    logic                              o_busy;
    logic                              o_done;
    logic [NB_IDX-1:0]                 o_idx;

    modport master (
        output i_start, i_abort, i_valid, i_coeff,
        input  o_ready, o_coeffs, o_busy, o_done, o_idx
    );

    modport slave (
        input  i_start, i_abort, i_valid, i_coeff,
        output o_ready, o_coeffs, o_busy, o_done, o_idx
    );
endinterface

// File: rtl/fir_coeff_loader.sv
// Collects N_COEFFS taps into a shadow buffer and commits them atomically; o_coeffs/o_done update
// one cycle after the last transfer. o_ready is high only while loading, so the source is stalled otherwise.
module fir_coeff_loader #(
    parameter int NB_COEFFS = 8,
    parameter int N_COEFFS  = 8,
    parameter int NB_IDX    = $clog2(N_COEFFS)
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    fir_coeff_loader_if.slave    bus
);
    localparam int                NB_BUS   = NB_COEFFS * N_COEFFS;
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_COEFFS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT
    } state_t;

    state_t              state_q, state_d;
    logic [NB_IDX-1:0]   idx_q, idx_d;
    logic [NB_BUS-1:0]   shadow_q, shadow_d;
    logic [NB_BUS-1:0]   coeffs_q, coeffs_d;
    logic                done_q, done_d;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            coeffs_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            coeffs_q <= coeffs_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        coeffs_d = coeffs_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                // Abort beats restart, restart beats a coincident transfer (that coefficient is dropped).
                if (bus.i_abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (bus.i_start) begin
                    idx_d = '0;
                end else if (bus.i_valid) begin
                    shadow_d[int'(idx_q)*NB_COEFFS +: NB_COEFFS] = bus.i_coeff;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_COMMIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                coeffs_d = shadow_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.o_ready  = (state_q == ST_LOAD);
    assign bus.o_busy   = (state_q != ST_IDLE);
    assign bus.o_done   = done_q;
    assign bus.o_idx    = idx_q;
    assign bus.o_coeffs = coeffs_q;
endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: reset, full loads with and without gaps, abort, restart, reset in COMMIT.
module tb_fir_coeff_loader;
    localparam int NB = 8;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fir_coeff_loader_if #(.NB_COEFFS(NB), .N_COEFFS(N)) bus ();

    fir_coeff_loader #(.NB_COEFFS(NB), .N_COEFFS(N)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full start + N transfers + commit; prev is the set that must stay visible until o_done.
    task automatic load_set(input logic [63:0] set_v, input logic [63:0] prev, input bit gaps);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        chk("load_entry_busy", 64'(bus.o_busy), 64'd1);
        chk("load_entry_idx", 64'(bus.o_idx), 64'd0);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 2));
                repeat (g) begin
                    bus.i_valid = 1'b0;
                    bus.i_coeff = 8'h33;
                    tick();
                    chk("gap_hold", bus.o_coeffs, prev);
                    chk("gap_idx", 64'(bus.o_idx), 64'(i));
                end
            end
            bus.i_valid = 1'b1;
            bus.i_coeff = set_v[i*NB +: NB];
            tick();
            bus.i_valid = 1'b0;
            chk("xfer_idx", 64'(bus.o_idx), 64'((i + 1) % N));
            chk("xfer_hold", bus.o_coeffs, prev);
        end
        chk("commit_busy", 64'(bus.o_busy), 64'd1);
        chk("commit_done", 64'(bus.o_done), 64'd0);
        chk("commit_ready", 64'(bus.o_ready), 64'd0);
        tick();
        chk("done_pulse", 64'(bus.o_done), 64'd1);
        chk("done_value", bus.o_coeffs, set_v);
        chk("done_busy", 64'(bus.o_busy), 64'd0);
        tick();
        chk("done_clear", 64'(bus.o_done), 64'd0);
        chk("value_kept", bus.o_coeffs, set_v);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_coeff = '0;
        tick();
        tick();
        chk("rst_coeffs", bus.o_coeffs, 64'd0);
        chk("rst_ready", 64'(bus.o_ready), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        chk("rst_idx", 64'(bus.o_idx), 64'd0);

        // Valid data and abort in IDLE must be ignored.
        rst_n       = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_coeff = 8'h7F;
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        tick();
        bus.i_valid = 1'b0;
        chk("idle_coeffs", bus.o_coeffs, 64'd0);
        chk("idle_ready", 64'(bus.o_ready), 64'd0);
        chk("idle_busy", 64'(bus.o_busy), 64'd0);
        chk("idle_idx", 64'(bus.o_idx), 64'd0);

        load_set(64'h0807060504030201, 64'd0, 1'b0);
        load_set(64'hC040FB05007F80FF, 64'h0807060504030201, 1'b1);
        load_set(64'h1122334455667788, 64'hC040FB05007F80FF, 1'b0);

        // Abort after four taps of a new set.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.i_valid = 1'b1;
            bus.i_coeff = 8'(8'h5A + i);
            tick();
        end
        chk("abort_pre_idx", 64'(bus.o_idx), 64'd4);
        bus.i_abort = 1'b1;
        bus.i_coeff = 8'hEE;
        tick();
        bus.i_abort = 1'b0;
        bus.i_valid = 1'b0;
        chk("abort_busy", 64'(bus.o_busy), 64'd0);
        chk("abort_ready", 64'(bus.o_ready), 64'd0);
        chk("abort_idx", 64'(bus.o_idx), 64'd0);
        chk("abort_done", 64'(bus.o_done), 64'd0);
        chk("abort_coeffs", bus.o_coeffs, 64'h1122334455667788);
        tick();
        chk("abort_done_late", 64'(bus.o_done), 64'd0);
        chk("abort_coeffs_late", bus.o_coeffs, 64'h1122334455667788);

        // Restart mid-load with a coincident valid: that coefficient is dropped.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.i_valid = 1'b1;
            bus.i_coeff = 8'hAA;
            tick();
        end
        bus.i_start = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_coeff = 8'hEE;
        tick();
        bus.i_start = 1'b0;
        chk("restart_idx", 64'(bus.o_idx), 64'd0);
        chk("restart_ready", 64'(bus.o_ready), 64'd1);
        for (int i = 0; i < N; i++) begin
            bus.i_valid = 1'b1;
            bus.i_coeff = 8'(8'h10 + i);
            tick();
        end
        bus.i_valid = 1'b0;
        chk("restart_hold", bus.o_coeffs, 64'h1122334455667788);
        tick();
        chk("restart_done", 64'(bus.o_done), 64'd1);
        chk("restart_value", bus.o_coeffs, 64'h1716151413121110);

        // Async reset while in COMMIT.
        tick();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.i_valid = 1'b1;
            bus.i_coeff = 8'(8'h30 + i);
            tick();
        end
        bus.i_valid = 1'b0;
        chk("pre_rst_busy", 64'(bus.o_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_coeffs", bus.o_coeffs, 64'd0);
        chk("async_rst_busy", 64'(bus.o_busy), 64'd0);
        chk("async_rst_done", 64'(bus.o_done), 64'd0);
        tick();
        rst_n = 1'b1;
        chk("rst_held_done", 64'(bus.o_done), 64'd0);
        tick();
        chk("post_rst_done", 64'(bus.o_done), 64'd0);
        chk("post_rst_coeffs", bus.o_coeffs, 64'd0);
        chk("post_rst_busy", 64'(bus.o_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Writer side of the FIR coefficient bus: accepts coefficients one per handshake from a serial source (register interface / test host).
- Assembles them into a shadow buffer; commits all N_COEFFS atomically to the packed bus that drives the FIR filter's i_coeffs.
- The filter never sees a partially updated coefficient set.

Parameters:
- NB_COEFFS, 8, width of one signed coefficient.
- N_COEFFS, 8, number of taps; must be >= 2.
- NB_IDX, $clog2(N_COEFFS), width of the tap index counter.

Ports:
- i_clock  in  1  system clock, rising-edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  pulse: begin a new load sequence.
- i_abort  in  1  pulse: discard the in-progress load.
- i_valid  in  1  i_coeff is valid this cycle.
- i_coeff  in  NB_COEFFS  signed coefficient, tap order 0 first.
- o_ready  out  1  loader accepts i_coeff this cycle.
- o_coeffs  out  NB_COEFFS*N_COEFFS  active packed set; tap k at bits [(k+1)*NB_COEFFS-1 -: NB_COEFFS].
- o_busy  out  1  high in LOAD or COMMIT.
- o_done  out  1  one-cycle pulse when a new set becomes active.
- o_idx  out  NB_IDX  index of the next tap to be written.

Behaviour:
- Reset (async assert, sync release): state IDLE, o_coeffs=0, shadow=0, o_idx=0, o_ready=0, o_busy=0, o_done=0.
- Transfer: occurs when i_valid && o_ready at a rising edge.
- o_ready is registered-state decoded: 1 only in LOAD.
- States: IDLE, LOAD, COMMIT.
- IDLE:
  - i_start -> LOAD with o_idx=0.
  - i_valid is ignored; no transfer because o_ready=0.
  - i_abort has no effect.
- LOAD, each transfer:
  - shadow[o_idx] <= i_coeff.
  - If o_idx==N_COEFFS-1: o_idx<=0 and go to COMMIT.
  - Otherwise o_idx<=o_idx+1.
  - Without i_valid the state and index hold indefinitely; no timeout.
- LOAD, priority in the same cycle is i_abort > i_start > transfer:
  - i_abort -> IDLE, o_idx=0, no commit, o_coeffs unchanged. Shadow contents are don't-care.
  - i_start -> stay in LOAD, o_idx=0, the coincident i_coeff is dropped.
- COMMIT (exactly 1 cycle):
  - o_coeffs <= shadow, all taps updated on the same edge.
  - o_done=1 in the cycle after COMMIT, aligned with the new o_coeffs value.
  - Next state IDLE.
  - i_start and i_abort are ignored in COMMIT.
- Latency: last transfer at edge T. COMMIT occupies cycle T..T+1. o_coeffs changes and o_done=1 at edge T+1.
- o_busy = (state != IDLE).
- o_done is registered, high for one cycle only. A back-to-back i_start in the o_done cycle is accepted normally.
- No arithmetic: coefficients are stored bit-exact, sign preserved, no saturation.
- Reset mid-LOAD or mid-COMMIT: immediate return to reset values, so o_coeffs goes to 0 even if a commit was pending.
- Outputs of all states are registered. o_coeffs is glitch-free between commits.

Test Plan:
- Reset then idle, N_COEFFS=8, NB_COEFFS=8 -> o_coeffs=0, o_ready=0, o_busy=0, o_done=0; i_valid with i_coeff=8'h7F while IDLE -> no change.
- i_start, then 8 back-to-back transfers 1,2,...,8 -> o_done one cycle after the 8th transfer; o_coeffs=64'h0807060504030201; o_busy low the same cycle.
- Load -1,-128,127,0,5,-5,64,-64 with random i_valid gaps -> o_coeffs=64'hC040FB05007F80FF; o_coeffs unchanged at every cycle before o_done.
- Load set A; start set B, write 4 taps, assert i_abort -> o_coeffs stays A, no o_done, state IDLE, o_idx=0.
- Mid-load i_start with i_valid in the same cycle -> that coefficient dropped, o_idx=0; 8 further transfers commit only those 8 values.
- i_reset_n low for 1 cycle during COMMIT -> o_coeffs=0 immediately (async), o_done never pulses.
